float_to_fixed_seq: RTL and testbench
=====================================

FLOAT_TO_FIXED_SEQ -- requirements
Module: float_to_fixed_seq

Interface
REQ-001 SHALL have parameter OUT_W, default 32, giving the signed fixed-point output width, legal range 8..64.
REQ-002 SHALL have parameter FP_W, default $clog2(OUT_W), giving the width of the fixpointpos input.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: a conversion request is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL have port float, input, 32 bits: IEEE-754 single-precision operand.
REQ-008 SHALL have port fixpointpos, input, FP_W bits: number of fraction bits in the result, legal range 0..OUT_W-1.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is present.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port result, output, OUT_W bits: two's-complement fixed-point result.
REQ-012 SHALL have port ovf, output, 1 bit: the result was saturated because of magnitude or infinity.
REQ-013 SHALL have port inv, output, 1 bit: the operand was a NaN.

Function
REQ-014 SHALL implement FSM states IDLE, ALIGN, FINISH and DONE; in_ready = (state==IDLE) && !rst.
REQ-015 SHALL accept on in_valid&&in_ready and register float and fixpointpos; later input changes have no effect.
REQ-016 SHALL compute e=exp-127 and sh=e+fixpointpos-23, using mantissa 1.m (24 bits) for normal operands.
REQ-017 SHALL treat exp==0 (zero or denormal) as result 0 with ovf=0 and inv=0, going IDLE->DONE in 1 edge.
REQ-018 SHALL treat NaN as result 2^(OUT_W-1)-1 with inv=1, going IDLE->DONE in 1 edge.
REQ-019 SHALL treat +/-Inf, or e+fixpointpos >= OUT_W-1, as result max (positive) or min (negative) with ovf=1, going IDLE->DONE in 1 edge.
REQ-020 SHALL otherwise load a shift counter with |sh|, with a right-shift count capped at 26; ALIGN shifts one bit per cycle (left if sh>0, right if sh<0) and decrements the counter.
REQ-021 SHALL, on right shifts, retain a guard bit and a sticky bit (OR of all bits shifted past the guard).
REQ-022 SHALL go to FINISH when the counter is 0, including immediately from IDLE when sh==0.
REQ-023 SHALL in FINISH apply rounding (REQ-030/031), then negate if the sign is 1, then go to DONE.
REQ-024 SHALL, if magnitude after rounding reaches or exceeds 2^(OUT_W-1), saturate the result and set ovf=1.
REQ-025 SHALL give a normal latency from the accept edge to out_valid high of min(|sh|,26)+2 edges.
REQ-026 SHALL in DONE hold result, ovf and inv stable while out_valid=1 and out_ready=0.
REQ-027 SHALL on out_ready in DONE go to IDLE and drop out_valid; there is no accept in the same cycle, so throughput is at most one result per latency+1 cycles.
REQ-028 SHALL give fixpointpos > OUT_W-1 undefined behaviour; the bench never drives it.

Reset
REQ-029 SHALL, when rst is asserted in any state including mid-ALIGN, immediately force state=IDLE, out_valid=0, result=0, ovf=0, inv=0 and clear the counter, guard and sticky; the in-flight request is discarded and in_ready rises on the first edge after rst falls.

Configuration
REQ-030 SHALL, when FTOF_ROUND_NEAREST_EN is defined, round right-shifted results to nearest, ties to even, using guard, sticky and LSB.
REQ-031 SHALL, when FTOF_ROUND_NEAREST_EN is undefined, truncate toward zero and leave guard/sticky logic unused; latency is identical in both builds.

Structure
REQ-032 SHALL have package ftof_pkg hold the FSM state enum, EXP_BIAS=127, MANT_W=23, EXP_W=8, EXP_MAX=8'hFF and the operand-class enum (ZERO, NORM, INF, NAN).
REQ-033 SHALL have one combinational sub-module, ftof_classify, decode the sign, operand class and unbiased exponent from float.

Verification
REQ-034 SHALL verify 0x3FC00000 (1.5), fixpointpos=4 -> result 0x00000018, ovf=0, inv=0, out_valid 21 edges after accept.
REQ-035 SHALL verify 0x47800000 (65536), fixpointpos=8 -> result 0x01000000 with latency 3 edges; 0xC0600000 (-3.5), fixpointpos=0 -> 0xFFFFFFFD when truncating, 0xFFFFFFFC with FTOF_ROUND_NEAREST_EN.
REQ-036 SHALL verify 0x4F000000 (2^31), fixpointpos=0 -> 0x7FFFFFFF, ovf=1, latency 1; 0xFF800000 (-Inf) -> 0x80000000, ovf=1.
REQ-037 SHALL verify 0x7FC00000 (NaN) -> 0x7FFFFFFF, inv=1, ovf=0; 0x00000001 (denormal) -> 0x00000000.
REQ-038 SHALL verify that with out_ready held low 10 cycles in DONE, result and flags stay stable, in_ready=0 and new in_valid is ignored; the result is delivered once when out_ready rises.
REQ-039 SHALL verify that rst pulsed 3 cycles into ALIGN for 1.5/fixpointpos=4 gives no out_valid, in_ready=1 the edge after release, and correct results for the next request.

Source files
------------

// File: rtl/ftof_pkg.sv
// Shared types and IEEE-754 single-precision constants for the float-to-fixed converter.
package ftof_pkg;
    localparam int unsigned      EXP_BIAS = 127;
    localparam int unsigned      MANT_W   = 23;
    localparam int unsigned      EXP_W    = 8;
    localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;

    // Right shifts beyond this leave only sticky information, so the count is capped.
    localparam int unsigned RSH_CAP = 26;
    localparam int unsigned EXPU_W  = 10;

    typedef enum logic [1:0] {IDLE, ALIGN, FINISH, DONE} state_e;
    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} opclass_e;
endpackage

// File: rtl/ftof_classify.sv
// Combinational decode of an IEEE-754 single into sign, operand class,
// unbiased exponent and 24-bit significand with the hidden one restored.
module ftof_classify
    import ftof_pkg::*;
(
    input  logic [31:0]              float_i,
    output logic                     sign_o,
    output opclass_e                 cls_o,
    output logic signed [EXPU_W-1:0] exp_o,
    output logic [MANT_W:0]          mant_o
);
    logic [EXP_W-1:0]  exp_bits;
    logic [MANT_W-1:0] frac_bits;

    always_comb begin
        sign_o    = float_i[31];
        exp_bits  = float_i[30:23];
        frac_bits = float_i[22:0];
        exp_o     = $signed({2'b00, exp_bits}) - $signed(EXPU_W'(EXP_BIAS));
        mant_o    = {1'b1, frac_bits};
        if (exp_bits == '0) begin
            cls_o = ZERO;
        end else if (exp_bits == EXP_MAX) begin
            cls_o = (frac_bits == '0) ? INF : NAN;
        end else begin
            cls_o = NORM;
        end
    end
endmodule

// File: rtl/float_to_fixed_seq.sv
// Sequential float32 -> signed fixed-point converter, aligning one bit per cycle.
// Define FTOF_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module float_to_fixed_seq
    import ftof_pkg::*;
#(
    parameter int OUT_W = 32,
    parameter int FP_W  = $clog2(OUT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      float,
    input  logic [FP_W-1:0]  fixpointpos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             ovf,
    output logic             inv
);
    localparam int MAG_W = (OUT_W > int'(MANT_W) + 1) ? OUT_W : int'(MANT_W) + 1;
    localparam int CNT_W = 7;

    localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    state_e                   state_q, state_d;
    logic                     sign_q, sign_d;
    logic                     left_q, left_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [MAG_W-1:0]         mag_q, mag_d;
    logic [OUT_W-1:0]         result_q, result_d;
    logic                     ovf_q, ovf_d;
    logic                     inv_q, inv_d;
`ifdef FTOF_ROUND_NEAREST_EN
    logic                     guard_q, guard_d;
    logic                     sticky_q, sticky_d;
`endif

    logic                     in_sign;
    opclass_e                 in_cls;
    logic signed [EXPU_W-1:0] in_exp;
    logic [MANT_W:0]          in_mant;

    logic signed [EXPU_W-1:0] efp;
    logic signed [EXPU_W-1:0] sh;
    logic [EXPU_W-1:0]        sh_abs;
    logic [EXPU_W-1:0]        sh_cnt;
    logic                     round_up;
    logic [MAG_W:0]           mag_rnd;
    logic [OUT_W-1:0]         mag_out;

    ftof_classify u_classify (
        .float_i (float),
        .sign_o  (in_sign),
        .cls_o   (in_cls),
        .exp_o   (in_exp),
        .mant_o  (in_mant)
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign inv       = inv_q;

`ifdef FTOF_ROUND_NEAREST_EN
    assign round_up = guard_q & (sticky_q | mag_q[0]);
`else
    assign round_up = 1'b0;
`endif

    always_comb begin
        efp    = in_exp + $signed(EXPU_W'(fixpointpos));
        sh     = efp - $signed(EXPU_W'(MANT_W));
        sh_abs = sh[EXPU_W-1] ? -sh : sh;
        if (sh[EXPU_W-1] && (sh_abs > EXPU_W'(RSH_CAP))) begin
            sh_cnt = EXPU_W'(RSH_CAP);
        end else begin
            sh_cnt = sh_abs;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        left_d   = left_q;
        cnt_d    = cnt_q;
        mag_d    = mag_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;
`ifdef FTOF_ROUND_NEAREST_EN
        guard_d  = guard_q;
        sticky_d = sticky_q;
`endif
        mag_rnd  = {1'b0, mag_q} + {{MAG_W{1'b0}}, round_up};
        mag_out  = mag_rnd[OUT_W-1:0];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = in_sign;
                    left_d   = 1'b0;
                    cnt_d    = '0;
                    mag_d    = MAG_W'(in_mant);
                    result_d = '0;
                    ovf_d    = 1'b0;
                    inv_d    = 1'b0;
`ifdef FTOF_ROUND_NEAREST_EN
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
`endif
                    // Special operands and certain overflow bypass the shifter entirely.
                    case (in_cls)
                        ZERO: state_d = DONE;
                        NAN: begin
                            result_d = MAX_POS;
                            inv_d    = 1'b1;
                            state_d  = DONE;
                        end
                        INF: begin
                            result_d = in_sign ? MIN_NEG : MAX_POS;
                            ovf_d    = 1'b1;
                            state_d  = DONE;
                        end
                        default: begin
                            if (efp >= $signed(EXPU_W'(OUT_W - 1))) begin
                                result_d = in_sign ? MIN_NEG : MAX_POS;
                                ovf_d    = 1'b1;
                                state_d  = DONE;
                            end else if (sh == '0) begin
                                state_d = FINISH;
                            end else begin
                                left_d  = !sh[EXPU_W-1];
                                cnt_d   = CNT_W'(sh_cnt);
                                state_d = ALIGN;
                            end
                        end
                    endcase
                end
            end
            ALIGN: begin
                if (left_q) begin
                    mag_d = mag_q << 1;
                end else begin
                    mag_d = mag_q >> 1;
`ifdef FTOF_ROUND_NEAREST_EN
                    guard_d  = mag_q[0];
                    sticky_d = sticky_q | guard_q;
`endif
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                // Rounding can carry into the sign position, so re-check range here.
                if (|mag_rnd[MAG_W:OUT_W-1]) begin
                    result_d = sign_q ? MIN_NEG : MAX_POS;
                    ovf_d    = 1'b1;
                end else begin
                    result_d = sign_q ? -mag_out : mag_out;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            left_q   <= 1'b0;
            cnt_q    <= '0;
            mag_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
`ifdef FTOF_ROUND_NEAREST_EN
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            left_q   <= left_d;
            cnt_q    <= cnt_d;
            mag_q    <= mag_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
`ifdef FTOF_ROUND_NEAREST_EN
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
`endif
        end
    end
endmodule

// File: tb/tb_float_to_fixed_seq.sv
// Directed self-checking bench for float_to_fixed_seq (OUT_W=32); honours FTOF_ROUND_NEAREST_EN.
module tb_float_to_fixed_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] fltIn = '0;
    logic [4:0]  fixPos = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] result;
    logic        ovf;
    logic        inv;

    int total = 0;
    int bad   = 0;
    int lat   = 0;

    float_to_fixed_seq #(.OUT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .float       (fltIn),
        .fixpointpos (fixPos),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .result      (result),
        .ovf         (ovf),
        .inv         (inv)
    );

    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here so the counters stay honest.
    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait for in_ready, present one request for a single accept edge, then
    // count edges (accept edge = 1) until out_valid rises or the budget runs out.
    task automatic applyStimulus(input string tag, input logic [31:0] f, input logic [4:0] fp);
        int waitCnt = 0;
        while (!inReady && waitCnt < 100) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkEq({tag, ".ready"}, 64'(inReady), 64'd1);
        fltIn   = f;
        fixPos  = fp;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        fltIn   = 32'hDEAD_BEEF;
        fixPos  = 5'd3;
        lat = 1;
        while (!outValid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Compare the held result against expectations, then hand it to the consumer.
    task automatic checkOutput(input string tag, input logic [31:0] expRes, input logic expOvf,
                               input logic expInv, input int expLat);
        checkEq({tag, ".valid"},  64'(outValid), 64'd1);
        checkEq({tag, ".result"}, 64'(result),   64'(expRes));
        checkEq({tag, ".ovf"},    64'(ovf),      64'(expOvf));
        checkEq({tag, ".inv"},    64'(inv),      64'(expInv));
        checkEq({tag, ".lat"},    64'(lat),      64'(expLat));
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkEq({tag, ".drop"},   64'(outValid), 64'd0);
    endtask

    initial begin
        logic [31:0] held;
        logic        seen;

        $display("[TB] reset state");
        #2;
        checkEq("rst.ready",  64'(inReady),  64'd0);
        checkEq("rst.valid",  64'(outValid), 64'd0);
        checkEq("rst.result", 64'(result),   64'd0);
        checkEq("rst.ovf",    64'(ovf),      64'd0);
        checkEq("rst.inv",    64'(inv),      64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkEq("rst.release", 64'(inReady), 64'd1);

        $display("[TB] normal conversions");
        applyStimulus("p1_5_fp4", 32'h3FC0_0000, 5'd4);
        checkOutput("p1_5_fp4", 32'h0000_0018, 1'b0, 1'b0, 21);
        applyStimulus("p65536_fp8", 32'h4780_0000, 5'd8);
        checkOutput("p65536_fp8", 32'h0100_0000, 1'b0, 1'b0, 3);
        applyStimulus("n3_5_fp0", 32'hC060_0000, 5'd0);
`ifdef FTOF_ROUND_NEAREST_EN
        checkOutput("n3_5_fp0", 32'hFFFF_FFFC, 1'b0, 1'b0, 24);
`else
        checkOutput("n3_5_fp0", 32'hFFFF_FFFD, 1'b0, 1'b0, 24);
`endif
        applyStimulus("p1_75_fp0", 32'h3FE0_0000, 5'd0);
`ifdef FTOF_ROUND_NEAREST_EN
        checkOutput("p1_75_fp0", 32'h0000_0002, 1'b0, 1'b0, 25);
`else
        checkOutput("p1_75_fp0", 32'h0000_0001, 1'b0, 1'b0, 25);
`endif
        applyStimulus("p0_5_fp0", 32'h3F00_0000, 5'd0);
        checkOutput("p0_5_fp0", 32'h0000_0000, 1'b0, 1'b0, 26);
        applyStimulus("p2_5_fp0", 32'h4020_0000, 5'd0);
        checkOutput("p2_5_fp0", 32'h0000_0002, 1'b0, 1'b0, 24);
        applyStimulus("n1_5_fp4", 32'hBFC0_0000, 5'd4);
        checkOutput("n1_5_fp4", 32'hFFFF_FFE8, 1'b0, 1'b0, 21);
        applyStimulus("p1_fp23", 32'h3F80_0000, 5'd23);
        checkOutput("p1_fp23", 32'h0080_0000, 1'b0, 1'b0, 2);
        applyStimulus("p0_5_fp31", 32'h3F00_0000, 5'd31);
        checkOutput("p0_5_fp31", 32'h4000_0000, 1'b0, 1'b0, 9);
        applyStimulus("tiny_fp0", 32'h3080_0000, 5'd0);
        checkOutput("tiny_fp0", 32'h0000_0000, 1'b0, 1'b0, 28);

        $display("[TB] special operands and saturation");
        applyStimulus("p2e31_fp0", 32'h4F00_0000, 5'd0);
        checkOutput("p2e31_fp0", 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        applyStimulus("p1_fp31", 32'h3F80_0000, 5'd31);
        checkOutput("p1_fp31", 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        applyStimulus("n1_fp31", 32'hBF80_0000, 5'd31);
        checkOutput("n1_fp31", 32'h8000_0000, 1'b1, 1'b0, 1);
        applyStimulus("ninf", 32'hFF80_0000, 5'd0);
        checkOutput("ninf", 32'h8000_0000, 1'b1, 1'b0, 1);
        applyStimulus("pinf", 32'h7F80_0000, 5'd7);
        checkOutput("pinf", 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        applyStimulus("nan", 32'h7FC0_0000, 5'd0);
        checkOutput("nan", 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
        applyStimulus("denorm", 32'h0000_0001, 5'd0);
        checkOutput("denorm", 32'h0000_0000, 1'b0, 1'b0, 1);

        $display("[TB] back-pressure in DONE");
        applyStimulus("bp", 32'h3FC0_0000, 5'd4);
        checkEq("bp.lat", 64'(lat), 64'd21);
        held    = result;
        checkEq("bp.first", 64'(held), 64'h18);
        fltIn   = 32'h4780_0000;
        fixPos  = 5'd8;
        inValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkEq("bp.hold_valid", 64'(outValid), 64'd1);
            checkEq("bp.hold_res",   64'(result),   64'h18);
            checkEq("bp.hold_ovf",   64'(ovf),      64'd0);
            checkEq("bp.hold_inv",   64'(inv),      64'd0);
            checkEq("bp.hold_rdy",   64'(inReady),  64'd0);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkEq("bp.drop",  64'(outValid), 64'd0);
        checkEq("bp.ready", 64'(inReady),  64'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            seen = seen | outValid;
        end
        checkEq("bp.once", 64'(seen), 64'd0);

        $display("[TB] reset mid-ALIGN");
        fltIn   = 32'h3FC0_0000;
        fixPos  = 5'd4;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkEq("mr.valid",  64'(outValid), 64'd0);
        checkEq("mr.ready",  64'(inReady),  64'd0);
        checkEq("mr.result", 64'(result),   64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkEq("mr.ready_after", 64'(inReady), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            seen = seen | outValid;
        end
        checkEq("mr.no_valid", 64'(seen), 64'd0);
        applyStimulus("mr_next", 32'h4780_0000, 5'd8);
        checkOutput("mr_next", 32'h0100_0000, 1'b0, 1'b0, 3);
        applyStimulus("mr_next2", 32'h3FC0_0000, 5'd4);
        checkOutput("mr_next2", 32'h0000_0018, 1'b0, 1'b0, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
